// File: rtl/pc_return_stack_if.sv
// pc_return_stack_if: control and status bundle between the fetch control unit and the PC/return stack
interface pc_return_stack_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] dIn;
  logic                  pcLd;
  logic                  pcInc;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] pcCount;
  logic [ADDR_WIDTH-1:0] stackTop;
  logic                  empty;
  logic                  full;
  logic                  err;
  modport master (
    output dIn, pcLd, pcInc, push, pop,
    input  pcCount, stackTop, empty, full, err
  );
  modport slave (
    input  dIn, pcLd, pcInc, push, pop,
    output pcCount, stackTop, empty, full, err
  );
endinterface

// File: rtl/pc_return_stack.sv
// pc_return_stack: fetch PC register with an integrated return-address stack
module pc_return_stack #(
  parameter int ADDR_WIDTH  = 10,
  parameter int STACK_DEPTH = 16
) (
  input logic                clk,
  input logic                rst,
  pc_return_stack_if.slave   bus
);
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = $clog2(STACK_DEPTH);
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [SPW-1:0]        sp_q, sp_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] mem_q [STACK_DEPTH];
  logic [ADDR_WIDTH-1:0] ret;
  logic                  sp_empty, sp_full, push_new, replace, pop_ok, flag, wr_en;
  logic [IW-1:0]         top_idx, wr_idx;
  assign ret      = pc_q + ADDR_WIDTH'(1);
  assign sp_empty = sp_q == '0;
  assign sp_full  = sp_q == SPW'(STACK_DEPTH);
  assign top_idx  = IW'(sp_q - SPW'(1));
  // Decode strobes: push+pop on a non-empty stack rewrites the top in place
  always_comb begin
    push_new = bus.push && (bus.pop ? sp_empty : !sp_full);
    replace  = bus.push && bus.pop && !sp_empty;
    pop_ok   = bus.pop && !bus.push && !sp_empty;
    flag     = (bus.push && !bus.pop && sp_full) || (bus.pop && !bus.push && sp_empty);
    wr_en    = push_new || replace;
    wr_idx   = replace ? top_idx : IW'(sp_q);
    sp_d     = push_new ? sp_q + SPW'(1) : pop_ok ? sp_q - SPW'(1) : sp_q;
    pc_d     = bus.pcLd ? bus.dIn : bus.pcInc ? ret : pc_q;
    err_d    = err_q | flag;
  end
  // PC, occupancy and sticky error state
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= '0;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end
  // Entry storage is not reset; it is invisible while the stack is empty
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_idx] <= ret;
  end
  assign bus.pcCount  = pc_q;
  assign bus.stackTop = sp_empty ? '0 : mem_q[top_idx];
  assign bus.empty    = sp_empty;
  assign bus.full     = sp_full;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_pc_return_stack.sv
// tb_pc_return_stack: directed checks of PC sequencing and return-stack behaviour
module tb_pc_return_stack;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  pc_return_stack_if #(.ADDR_WIDTH(10)) bus ();
  pc_return_stack #(.ADDR_WIDTH(10), .STACK_DEPTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask
  task automatic idle();
    bus.dIn = '0; bus.pcLd = 0; bus.pcInc = 0; bus.push = 0; bus.pop = 0; rst = 0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask
  initial begin
    idle();
    rst = 1; step();
    chk("rst_pc", bus.pcCount, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_top", bus.stackTop, 0);
    for (int i = 0; i < 5; i++) begin bus.pcInc = 1; step(); end
    chk("inc_pc", bus.pcCount, 10'h005);
    chk("inc_empty", bus.empty, 1);
    chk("inc_top", bus.stackTop, 0);
    bus.dIn = 10'h120; bus.pcLd = 1; bus.push = 1; step();
    chk("call_pc", bus.pcCount, 10'h120);
    chk("call_top", bus.stackTop, 10'h006);
    chk("call_empty", bus.empty, 0);
    bus.dIn = bus.stackTop; bus.pcLd = 1; bus.pop = 1; step();
    chk("ret_pc", bus.pcCount, 10'h006);
    chk("ret_empty", bus.empty, 1);
    chk("ret_err", bus.err, 0);
    bus.dIn = 10'h3FF; bus.pcLd = 1; step();
    chk("ld_pc", bus.pcCount, 10'h3FF);
    bus.pcInc = 1; step();
    chk("wrap_pc", bus.pcCount, 10'h000);
    bus.dIn = 10'h100; bus.pcLd = 1; bus.pcInc = 1; step();
    chk("ld_prio_pc", bus.pcCount, 10'h100);
    for (int i = 0; i < 16; i++) begin bus.push = 1; bus.pcInc = 1; step(); end
    chk("fill_full", bus.full, 1);
    chk("fill_top", bus.stackTop, 10'h110);
    chk("fill_err", bus.err, 0);
    chk("fill_pc", bus.pcCount, 10'h110);
    bus.push = 1; step();
    chk("ovf_err", bus.err, 1);
    chk("ovf_full", bus.full, 1);
    chk("ovf_top", bus.stackTop, 10'h110);
    bus.pop = 1; step();
    chk("ovf_pop_top", bus.stackTop, 10'h10F);
    chk("ovf_pop_full", bus.full, 0);
    chk("ovf_sticky", bus.err, 1);
    rst = 1; step();
    chk("rst2_err", bus.err, 0);
    bus.pop = 1; step();
    chk("unf_err", bus.err, 1);
    chk("unf_empty", bus.empty, 1);
    bus.push = 1; step();
    chk("unf_push_top", bus.stackTop, 10'h001);
    bus.pop = 1; step();
    chk("unf_pop_empty", bus.empty, 1);
    chk("unf_sticky", bus.err, 1);
    rst = 1; step();
    chk("rst3_err", bus.err, 0);
    bus.dIn = 10'h00F; bus.pcLd = 1; step();
    bus.dIn = 10'h040; bus.pcLd = 1; bus.push = 1; step();
    chk("pp_pre_top", bus.stackTop, 10'h010);
    chk("pp_pre_pc", bus.pcCount, 10'h040);
    bus.push = 1; bus.pop = 1; step();
    chk("pp_top", bus.stackTop, 10'h041);
    chk("pp_err", bus.err, 0);
    bus.pop = 1; step();
    chk("pp_depth1", bus.empty, 1);
    bus.push = 1; bus.pop = 1; step();
    chk("pp0_top", bus.stackTop, 10'h041);
    chk("pp0_empty", bus.empty, 0);
    bus.pop = 1; step();
    chk("pp0_depth1", bus.empty, 1);
    chk("pp0_err", bus.err, 0);
    for (int i = 0; i < 3; i++) begin bus.push = 1; bus.pcInc = 1; step(); end
    chk("mid_top", bus.stackTop, 10'h043);
    chk("mid_pc", bus.pcCount, 10'h043);
    rst = 1; bus.dIn = 10'h200; bus.pcLd = 1; bus.pop = 1; step();
    chk("mid_rst_pc", bus.pcCount, 0);
    chk("mid_rst_empty", bus.empty, 1);
    chk("mid_rst_err", bus.err, 0);
    chk("mid_rst_top", bus.stackTop, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
